// File: rtl/switch_schedule_pkg.sv
// switch_schedule_pkg
// Shared types and helpers for the switch schedule sequencer.
//   sched_state_t : sequencer state (IDLE / RUN / DONE)
//   INIT_OFF/ON   : legal values for the INIT parameter
//   count_width   : width needed to hold 0..depth entries
//   addr_width    : width needed to index depth entries
package switch_schedule_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

  localparam logic INIT_OFF = 1'b0;
  localparam logic INIT_ON  = 1'b1;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/switch_schedule_list.sv
// switch_schedule_list
// DEPTH x TW register file holding the toggle-time list.
// Ports:
//   clk_i, rst_n_i   : clock, synchronous active-low reset
//   clear_i          : empty the list
//   push_i           : append push_data_i at index count
//   ptr_i            : read index for the run-time compare
//   rd_data_o        : list[ptr_i]
//   last_time_o      : list[count-1] (0 when empty), for the monotonic check
//   count_o          : number of stored entries
module switch_schedule_list
  import switch_schedule_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TW    = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          clear_i,
  input  logic                          push_i,
  input  logic [TW-1:0]                 push_data_i,
  input  logic [count_width(DEPTH)-1:0] ptr_i,
  output logic [TW-1:0]                 rd_data_o,
  output logic [TW-1:0]                 last_time_o,
  output logic [count_width(DEPTH)-1:0] count_o
);

  localparam int CW = count_width(DEPTH);
  localparam int AW = addr_width(DEPTH);

  logic [TW-1:0] mem_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_idx, rd_idx, last_idx;

  // Writers only push while count < DEPTH and only read at ptr < count,
  // so truncating to the address width never aliases a live entry.
  assign wr_idx   = AW'(count_q);
  assign rd_idx   = AW'(ptr_i);
  assign last_idx = AW'(count_q - CW'(1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (push_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (clear_i) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_i) begin
        mem_q[wr_idx] <= push_data_i;
      end
    end
  end

  assign rd_data_o   = mem_q[rd_idx];
  assign last_time_o = (count_q == '0) ? '0 : mem_q[last_idx];
  assign count_o     = count_q;

endmodule

// File: rtl/switch_schedule_seq.sv
// switch_schedule_seq
// Generates the on/off control level for a downstream analog switch from a
// list of absolute toggle ticks, either as a single pass or periodically.
//
//   state | meaning
//   IDLE  | accepting toggle-time entries, waiting for start
//   RUN   | timer counting, sw_on flips on each listed tick
//   DONE  | run finished or aborted, sw_on held; start reruns
//
// Ports:
//   clk_i, rst_n_i   : clock, synchronous active-low reset
//   load_valid_i/load_time_i/load_ready_o : toggle-time entry handshake
//   start_i          : begin/restart a run
//   repeat_en_i      : periodic mode, sampled with an accepted start
//   abort_i          : stop the run, hold sw_on
//   clear_i          : empty the list, return to IDLE, sw_on <- INIT
//   sw_on_o          : switch control level
//   toggle_pulse_o   : first cycle of a new sw_on level
//   busy_o, done_o   : state is RUN / DONE
//   err_o            : sticky, an entry was rejected
//   count_o          : number of stored entries
module switch_schedule_seq
  import switch_schedule_pkg::*;
#(
  parameter int   DEPTH = 8,
  parameter int   TW    = 32,
  parameter logic INIT  = INIT_OFF
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          load_valid_i,
  input  logic [TW-1:0]                 load_time_i,
  output logic                          load_ready_o,
  input  logic                          start_i,
  input  logic                          repeat_en_i,
  input  logic                          abort_i,
  input  logic                          clear_i,
  output logic                          sw_on_o,
  output logic                          toggle_pulse_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [count_width(DEPTH)-1:0] count_o
);

  localparam int CW = count_width(DEPTH);

  sched_state_t  state_q;
  logic [TW-1:0] timer_q;
  logic [CW-1:0] ptr_q;
  logic          sw_q, pulse_q, err_q, busy_q, done_q, repeat_q;

  logic [TW-1:0] rd_data, last_time;
  logic [CW-1:0] count;
  logic          load_fire, load_bad, push, match, last_hit, start_ok;

  assign load_ready_o = (state_q == ST_IDLE) && (count < CW'(DEPTH));
  assign load_fire    = load_valid_i && load_ready_o;
  // Rejected entries are still consumed; they only raise err.
  assign load_bad     = (load_time_i == '0) ||
                        ((count != '0) && (load_time_i <= last_time));
  assign push         = load_fire && !load_bad && !clear_i;

  assign match    = (state_q == ST_RUN) && (timer_q == rd_data);
  assign last_hit = (ptr_q == count - CW'(1));
  // An entry stored in the start cycle counts toward a non-empty list.
  assign start_ok = start_i &&
                    ((state_q == ST_DONE) ||
                     ((state_q == ST_IDLE) && ((count != '0) || push)));

  switch_schedule_list #(
    .DEPTH(DEPTH),
    .TW   (TW)
  ) u_list (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clear_i    (clear_i),
    .push_i     (push),
    .push_data_i(load_time_i),
    .ptr_i      (ptr_q),
    .rd_data_o  (rd_data),
    .last_time_o(last_time),
    .count_o    (count)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      ptr_q    <= '0;
      sw_q     <= INIT;
      pulse_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      repeat_q <= 1'b0;
    end else if (clear_i) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      ptr_q    <= '0;
      sw_q     <= INIT;
      pulse_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (load_fire && load_bad) err_q <= 1'b1;

      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state_q  <= ST_RUN;
            timer_q  <= '0;
            ptr_q    <= '0;
            repeat_q <= repeat_en_i;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (match) begin
            sw_q    <= ~sw_q;
            pulse_q <= 1'b1;
            if (!last_hit) begin
              ptr_q   <= ptr_q + CW'(1);
              timer_q <= timer_q + TW'(1);
            end else if (repeat_q) begin
              // Restart at 1 so the period equals the last entry.
              ptr_q   <= '0;
              timer_q <= TW'(1);
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sw_on_o        = sw_q;
  assign toggle_pulse_o = pulse_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign count_o        = count;

endmodule
